// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu_if
// Brief    : Word-wide req/ack data bus between the MEM-stage LSU and memory.
// Revision : 1.0
// ============================================================================
interface mem_stage_lsu_if;
    logic        busReq;
    logic        busWe;
    logic [31:0] busAddr;
    logic [3:0]  busBe;
    logic [31:0] busWdata;
    logic        busAck;
    logic [31:0] busRdata;

    modport master (
        output busReq, busWe, busAddr, busBe, busWdata,
        input  busAck, busRdata
    );

    modport slave (
        input  busReq, busWe, busAddr, busBe, busWdata,
        output busAck, busRdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_lsu
// Brief    : MEM-stage load/store responder; stalls the pipeline across a
//            variable-latency req/ack bus access and formats load data.
// Revision : 1.0
// ============================================================================
module mem_stage_lsu #(
    parameter int ACK_TIMEOUT = 255,
    parameter int TO_W        = 16
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        memWrtm,
    input  wire logic        readm,
    input  wire logic [2:0]  funct3m,
    input  wire logic [31:0] aluRsltm,
    input  wire logic [31:0] wrtDm,
    output logic             stall,
    output logic [31:0]      loadData,
    output logic             ldValid,
    output logic             fault,
    mem_stage_lsu_if.master  bus
);

    localparam logic [TO_W-1:0] c_TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_next;

    logic            r_bus_req;
    logic            r_bus_we;
    logic [31:0]     r_bus_addr;
    logic [3:0]      r_bus_be;
    logic [31:0]     r_bus_wdata;
    logic [1:0]      r_size;
    logic            r_uns;
    logic [1:0]      r_off;
    logic [TO_W-1:0] r_to_cnt;
    logic [31:0]     r_load_data;
    logic            r_ld_valid;
    logic            r_fault;

    logic            w_req;
    logic            w_f3_ok;
    logic            w_misal;
    logic            w_accept;
    logic            w_reject;
    logic            w_to_hit;
    logic [3:0]      w_be;
    logic [31:0]     w_wdata;
    logic [31:0]     w_shift;
    logic [31:0]     w_fmt;

    // Request decode: a simultaneous write and read strobe is treated as a store.
    always_comb begin
        w_req   = memWrtm | readm;
        w_f3_ok = memWrtm ? (funct3m inside {3'b000, 3'b001, 3'b010})
                          : (funct3m inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        w_misal = ((funct3m[1:0] == 2'b01) && aluRsltm[0]) ||
                  ((funct3m[1:0] == 2'b10) && (aluRsltm[1:0] != 2'b00));
        w_accept = w_req && w_f3_ok && !w_misal;
        w_reject = w_req && !(w_f3_ok && !w_misal);
        w_to_hit = (r_to_cnt == c_TO_LAST);
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = wrtDm;
        if (memWrtm) begin
            case (funct3m[1:0])
                2'b00: begin
                    w_be    = 4'b0001 << aluRsltm[1:0];
                    w_wdata = {4{wrtDm[7:0]}};
                end
                2'b01: begin
                    w_be    = 4'b0011 << {aluRsltm[1], 1'b0};
                    w_wdata = {2{wrtDm[15:0]}};
                end
                default: begin
                    w_be    = 4'b1111;
                    w_wdata = wrtDm;
                end
            endcase
        end
    end

    // Load lane select uses the offset latched at issue, not the live address.
    always_comb begin
        w_shift = bus.busRdata >> {r_off, 3'b000};
        case (r_size)
            2'b00:   w_fmt = r_uns ? {24'd0, w_shift[7:0]}
                                   : {{24{w_shift[7]}}, w_shift[7:0]};
            2'b01:   w_fmt = r_uns ? {16'd0, w_shift[15:0]}
                                   : {{16{w_shift[15]}}, w_shift[15:0]};
            default: w_fmt = bus.busRdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        stall  = 1'b0;
        case (r_state)
            S_IDLE: begin
                stall = w_accept;
                if (w_accept) begin
                    w_next = S_BUSY;
                end
            end
            S_BUSY: begin
                stall = 1'b1;
                if (bus.busAck || w_to_hit) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (rst) begin
            stall = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_be    <= 4'd0;
            r_bus_wdata <= 32'd0;
            r_size      <= 2'd0;
            r_uns       <= 1'b0;
            r_off       <= 2'd0;
            r_to_cnt    <= '0;
            r_load_data <= 32'd0;
            r_ld_valid  <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_ld_valid <= 1'b0;
            r_fault    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= memWrtm;
                        r_bus_addr  <= {aluRsltm[31:2], 2'b00};
                        r_bus_be    <= w_be;
                        r_bus_wdata <= w_wdata;
                        r_size      <= funct3m[1:0];
                        r_uns       <= funct3m[2];
                        r_off       <= aluRsltm[1:0];
                        r_to_cnt    <= '0;
                    end else if (w_reject) begin
                        r_fault <= 1'b1;
                    end
                end
                S_BUSY: begin
                    // An ack coinciding with counter expiry completes the access.
                    if (bus.busAck) begin
                        r_bus_req <= 1'b0;
                        if (!r_bus_we) begin
                            r_load_data <= w_fmt;
                            r_ld_valid  <= 1'b1;
                        end
                    end else if (w_to_hit) begin
                        r_bus_req   <= 1'b0;
                        r_load_data <= 32'd0;
                        r_fault     <= 1'b1;
                    end else begin
                        r_to_cnt <= r_to_cnt + TO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.busReq   = r_bus_req;
    assign bus.busWe    = r_bus_we;
    assign bus.busAddr  = r_bus_addr;
    assign bus.busBe    = r_bus_be;
    assign bus.busWdata = r_bus_wdata;
    assign loadData     = r_load_data;
    assign ldValid      = r_ld_valid;
    assign fault        = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_stage_lsu
// Brief    : Scoreboard bench for mem_stage_lsu with a programmable-latency bus.
// Revision : 1.0
// ============================================================================
module tb_mem_stage_lsu;

    localparam int c_ACK_TIMEOUT = 4;
    localparam int c_OK = 0, c_REJECT = 1, c_TIMEOUT = 2;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        logic        chk_data;
        logic [31:0] data;
    } flt_exp_t;

    logic        clk;
    logic        rst;
    logic        memWrtm;
    logic        readm;
    logic [2:0]  funct3m;
    logic [31:0] aluRsltm;
    logic [31:0] wrtDm;
    logic        stall;
    logic [31:0] loadData;
    logic        ldValid;
    logic        fault;

    int          ack_delay;
    logic [31:0] cfg_rdata;
    int          n_pass;
    int          n_total;

    bus_exp_t    bus_q[$];
    int          reqlen_q[$];
    int          stall_q[$];
    logic [31:0] ld_q[$];
    flt_exp_t    flt_q[$];

    mem_stage_lsu_if bus_if ();

    mem_stage_lsu #(
        .ACK_TIMEOUT (c_ACK_TIMEOUT),
        .TO_W        (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .memWrtm  (memWrtm),
        .readm    (readm),
        .funct3m  (funct3m),
        .aluRsltm (aluRsltm),
        .wrtDm    (wrtDm),
        .stall    (stall),
        .loadData (loadData),
        .ldValid  (ldValid),
        .fault    (fault),
        .bus      (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", name, act, exp);
    endtask

    task automatic unexpected(input string name);
        n_total++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Bus slave: acks after ack_delay cycles of busReq (negative = never).
    initial begin
        int n;
        n = 0;
        bus_if.busAck   = 1'b0;
        bus_if.busRdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            bus_if.busRdata = cfg_rdata;
            if (bus_if.busReq) begin
                bus_if.busAck = (ack_delay >= 0) && (n == ack_delay);
                n++;
            end else begin
                bus_if.busAck = 1'b0;
                n = 0;
            end
        end
    end

    // Monitor: pops the matching queue whenever the DUT presents an event.
    initial begin
        int       scnt;
        int       rcnt;
        logic     prev_req;
        bus_exp_t be_e;
        flt_exp_t fe;
        scnt = 0;
        rcnt = 0;
        prev_req = 1'b0;
        forever begin
            @(negedge clk);
            if (bus_if.busReq && !prev_req) begin
                if (bus_q.size() == 0) unexpected("bus_start");
                else begin
                    be_e = bus_q.pop_front();
                    chk("busAddr", bus_if.busAddr, be_e.addr);
                    chk("busBe", {28'd0, bus_if.busBe}, {28'd0, be_e.be});
                    chk("busWe", {31'd0, bus_if.busWe}, {31'd0, be_e.we});
                    if (be_e.we) chk("busWdata", bus_if.busWdata, be_e.wdata);
                end
            end
            prev_req = bus_if.busReq;
            if (bus_if.busReq) rcnt++;
            else if (rcnt > 0) begin
                if (reqlen_q.size() == 0) unexpected("busReq_end");
                else chk("busReq_cycles", rcnt, reqlen_q.pop_front());
                rcnt = 0;
            end
            if (stall) scnt++;
            else if (scnt > 0) begin
                if (stall_q.size() == 0) unexpected("stall_end");
                else chk("stall_cycles", scnt, stall_q.pop_front());
                scnt = 0;
            end
            if (ldValid) begin
                if (ld_q.size() == 0) unexpected("ldValid");
                else chk("loadData", loadData, ld_q.pop_front());
            end
            if (fault) begin
                if (flt_q.size() == 0) unexpected("fault");
                else begin
                    fe = flt_q.pop_front();
                    if (fe.chk_data) chk("fault_loadData", loadData, fe.data);
                end
            end
            if (ldValid && fault) unexpected("ldValid_and_fault");
        end
    end

    task automatic issue(input logic we, input logic rd, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int delay, input int outcome,
                         input logic [3:0] ebe, input logic [31:0] ewd,
                         input logic [31:0] eld);
        bit done;
        int rl;
        if (outcome != c_REJECT) begin
            rl = (outcome == c_TIMEOUT) ? c_ACK_TIMEOUT : delay + 1;
            bus_q.push_back('{{addr[31:2], 2'b00}, ebe, we, ewd});
            reqlen_q.push_back(rl);
            stall_q.push_back(rl + 1);
        end
        if (outcome == c_OK && !we) ld_q.push_back(eld);
        if (outcome == c_TIMEOUT) flt_q.push_back('{1'b1, 32'd0});
        if (outcome == c_REJECT) flt_q.push_back('{1'b0, 32'd0});
        ack_delay = (outcome == c_TIMEOUT) ? -1 : delay;
        cfg_rdata = rdata;
        @(posedge clk);
        #1;
        memWrtm  = we;
        readm    = rd;
        funct3m  = f3;
        aluRsltm = addr;
        wrtDm    = wd;
        done = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!stall) begin
                done = 1;
                break;
            end
        end
        if (!done) unexpected("stall_timeout");
        @(posedge clk);
        #1;
        memWrtm = 1'b0;
        readm   = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        rst = 1'b1;
        memWrtm = 1'b0;
        readm = 1'b0;
        funct3m = 3'd0;
        aluRsltm = 32'd0;
        wrtDm = 32'd0;
        ack_delay = -1;
        cfg_rdata = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busReq", {31'd0, bus_if.busReq}, 32'd0);
        chk("rst_busWe", {31'd0, bus_if.busWe}, 32'd0);
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_ldValid", {31'd0, ldValid}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_busAddr", bus_if.busAddr, 32'd0);
        chk("rst_busBe", {28'd0, bus_if.busBe}, 32'd0);
        chk("rst_busWdata", bus_if.busWdata, 32'd0);
        chk("rst_loadData", loadData, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        //     we    rd    f3      addr          wd            rdata         dly outcome    be       wdata         load
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, c_OK,     4'b1111, 32'h0,        32'hDEAD_BEEF);
        issue(1'b0, 1'b1, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, c_OK,     4'b1111, 32'h0,        32'hFFFF_FF80);
        issue(1'b0, 1'b1, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_1234, 0, c_OK,     4'b1111, 32'h0,        32'h0000_0080);
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_1234, 0, c_OK,     4'b1111, 32'h0,        32'hFFFF_80FF);
        issue(1'b0, 1'b1, 3'b101, 32'h0000_0102, 32'h0,        32'h80FF_1234, 1, c_OK,     4'b1111, 32'h0,        32'h0000_80FF);
        issue(1'b1, 1'b0, 3'b000, 32'h0000_0201, 32'h0000_00AB, 32'h0,       1, c_OK,     4'b0010, 32'hABAB_ABAB, 32'h0);
        issue(1'b1, 1'b0, 3'b001, 32'h0000_0202, 32'h0000_1234, 32'h0,       2, c_OK,     4'b1100, 32'h1234_1234, 32'h0);
        issue(1'b1, 1'b0, 3'b010, 32'h0000_0204, 32'hCAFE_F00D, 32'h0,       0, c_OK,     4'b1111, 32'hCAFE_F00D, 32'h0);
        issue(1'b1, 1'b1, 3'b000, 32'h0000_0000, 32'h0000_007F, 32'h0,       0, c_OK,     4'b0001, 32'h7F7F_7F7F, 32'h0);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        0, c_REJECT, 4'b0000, 32'h0,        32'h0);
        issue(1'b0, 1'b1, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        0, c_REJECT, 4'b0000, 32'h0,        32'h0);
        issue(1'b0, 1'b1, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        0, c_REJECT, 4'b0000, 32'h0,        32'h0);
        issue(1'b1, 1'b0, 3'b100, 32'h0000_0100, 32'h0,        32'h0,        0, c_REJECT, 4'b0000, 32'h0,        32'h0);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0,        32'h5555_5555, 0, c_TIMEOUT, 4'b1111, 32'h0,       32'h0);
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0300, 32'h0,        32'h1234_5678, 3, c_OK,     4'b1111, 32'h0,        32'h1234_5678);

        // Reset in the second BUSY cycle of a load that is never acked.
        bus_q.push_back('{32'h0000_0100, 4'b1111, 1'b0, 32'h0});
        reqlen_q.push_back(2);
        stall_q.push_back(2);
        ack_delay = -1;
        @(posedge clk);
        #1;
        readm = 1'b1;
        funct3m = 3'b010;
        aluRsltm = 32'h0000_0100;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        readm = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("midrst_busReq", {31'd0, bus_if.busReq}, 32'd0);
        chk("midrst_stall", {31'd0, stall}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        issue(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'h0,        32'hA5A5_5A5A, 0, c_OK,     4'b1111, 32'h0,        32'hA5A5_5A5A);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("bus_q_left", bus_q.size(), 32'd0);
        chk("reqlen_q_left", reqlen_q.size(), 32'd0);
        chk("stall_q_left", stall_q.size(), 32'd0);
        chk("ld_q_left", ld_q.size(), 32'd0);
        chk("flt_q_left", flt_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
